// File: rtl/add_mop_acc_pkg.sv
// add_mop_acc_pkg
//   Shared definitions for the masked multi-operand accumulator:
//   - state_t : job controller states (ACC accumulating, HOLD result pending)
//   - DEF_*   : default parameter values used by add_mop_acc
package add_mop_acc_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_SPEED = 1;
  localparam int DEF_CNTW  = 8;

endpackage

// File: rtl/add_mop_acc_addmop.sv
// AddMop
//   Single-cycle modular reduction of `depth` unsigned operands of `width`
//   bits each. The result is the operand sum modulo 2^width.
//   Ports:
//     ops_i [depth*width] : operand k at bits [k*width +: width]
//     sum_o [width]       : sum of all operands, modulo 2^width
//   speed > 0 selects a balanced adder tree (shorter critical path),
//   speed = 0 selects a linear adder chain.
module AddMop #(
  parameter int width = 8,
  parameter int depth = 5,
  parameter int speed = 1
) (
  input  logic [depth*width-1:0] ops_i,
  output logic [width-1:0]       sum_o
);

  localparam int NP = 1 << $clog2(depth);

  function automatic logic [width-1:0] sum_chain(input logic [depth*width-1:0] ops);
    logic [width-1:0] s;
    s = '0;
    for (int k = 0; k < depth; k++) begin
      s = s + ops[k*width +: width];
    end
    return s;
  endfunction

  // Pairwise tree over a power-of-two slot array; unused slots hold zero.
  function automatic logic [width-1:0] sum_tree(input logic [depth*width-1:0] ops);
    logic [width-1:0] t [NP];
    for (int k = 0; k < NP; k++) begin
      t[k] = '0;
    end
    for (int k = 0; k < depth; k++) begin
      t[k] = ops[k*width +: width];
    end
    for (int s = 1; s < NP; s = s * 2) begin
      for (int i = 0; i + s < NP; i = i + 2 * s) begin
        t[i] = t[i] + t[i+s];
      end
    end
    return t[0];
  endfunction

  generate
    if (speed > 0) begin : g_tree
      assign sum_o = sum_tree(ops_i);
    end else begin : g_chain
      assign sum_o = sum_chain(ops_i);
    end
  endgenerate

endmodule

// File: rtl/add_mop_acc.sv
// add_mop_acc
//   Accumulates masked lanes of input beats into a job sum. A beat with
//   in_last_i closes the job; the result is then held (HOLD) until the
//   consumer accepts it, after which the accumulator restarts from zero.
//   Ports:
//     clk_i, rst_i            : clock, synchronous active-high reset
//     in_valid_i/in_ready_o   : input beat handshake
//     in_data_i [depth*width] : lane k at [k*width +: width]
//     in_mask_i [depth]       : lane k contributes when bit k is set
//     in_last_i               : beat closes the current job
//     abort_i                 : drop the partially accumulated job (ACC only)
//     out_valid_o/out_ready_i : result handshake
//     out_sum_o [width]       : job sum modulo 2^width
//     out_count_o [cntw]      : masked-in operand count modulo 2^cntw
//     out_ovf_o               : sum carry loss or count wrap seen in the job
module add_mop_acc
  import add_mop_acc_pkg::*;
#(
  parameter int width = DEF_WIDTH,
  parameter int depth = DEF_DEPTH,
  parameter int speed = DEF_SPEED,
  parameter int cntw  = DEF_CNTW
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [depth*width-1:0] in_data_i,
  input  logic [depth-1:0]       in_mask_i,
  input  logic                   in_last_i,
  input  logic                   abort_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [width-1:0]       out_sum_o,
  output logic [cntw-1:0]        out_count_o,
  output logic                   out_ovf_o
);

  localparam int NOPS = depth + 1;
  localparam int OPW  = $clog2(NOPS);
  localparam int WW   = width + OPW;   // holds the exact sum of NOPS operands
  localparam int CNW  = cntw + OPW;    // holds cnt + popcount without loss

  state_t               r_state;
  state_t               w_state_nxt;
  logic [width-1:0]     r_acc;
  logic [cntw-1:0]      r_cnt;
  logic                 r_ovf;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_clear;
  logic [NOPS*width-1:0] w_ops;
  logic [width-1:0]     w_sum;
  logic [WW-1:0]        w_wide;
  logic                 w_carry;
  logic [OPW-1:0]       w_pop;
  logic [CNW-1:0]       w_cnt_wide;
  logic                 w_wrap;

  function automatic logic [OPW-1:0] popcount(input logic [depth-1:0] m);
    logic [OPW-1:0] c;
    c = '0;
    for (int k = 0; k < depth; k++) begin
      c = c + OPW'(m[k]);
    end
    return c;
  endfunction

  // Exact-width sum, used only to detect carry loss out of the width-bit sum.
  function automatic logic [WW-1:0] wide_sum(input logic [NOPS*width-1:0] ops);
    logic [WW-1:0] s;
    s = '0;
    for (int k = 0; k < NOPS; k++) begin
      s = s + WW'(ops[k*width +: width]);
    end
    return s;
  endfunction

  // Operand 0 is the accumulator, operand k+1 is lane k gated by its mask bit.
  always_comb begin
    w_ops = '0;
    w_ops[width-1:0] = r_acc;
    for (int k = 0; k < depth; k++) begin
      w_ops[(k+1)*width +: width] = in_mask_i[k] ? in_data_i[k*width +: width] : '0;
    end
  end

  AddMop #(
    .width(width),
    .depth(NOPS),
    .speed(speed)
  ) u_addmop (
    .ops_i(w_ops),
    .sum_o(w_sum)
  );

  assign w_wide     = wide_sum(w_ops);
  assign w_carry    = |w_wide[WW-1:width];
  assign w_pop      = popcount(in_mask_i);
  assign w_cnt_wide = CNW'(r_cnt) + CNW'(w_pop);
  assign w_wrap     = |w_cnt_wide[CNW-1:cntw];

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_accept    = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ACC: begin
        w_in_ready = ~abort_i;
        w_accept   = in_valid_i & ~abort_i;
        if (abort_i) begin
          w_clear = 1'b1;
        end else if (w_accept && in_last_i) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          w_clear     = 1'b1;
          w_state_nxt = ACC;
        end
      end
      default: begin
        w_state_nxt = ACC;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Accumulator registers also hold the result while in HOLD.
  always_ff @(posedge clk_i) begin
    if (rst_i || w_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_cnt <= w_cnt_wide[cntw-1:0];
      r_ovf <= r_ovf | w_carry | w_wrap;
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = (r_state == HOLD);
  assign out_sum_o   = r_acc;
  assign out_count_o = r_cnt;
  assign out_ovf_o   = r_ovf;

endmodule

// File: tb/tb_add_mop_acc.sv
module tb_add_mop_acc;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [D*W-1:0] in_data_i = '0;
  logic [D-1:0]  in_mask_i = '0;
  logic          in_last_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [W-1:0]  out_sum_o;
  logic [CW-1:0] out_count_o;
  logic          out_ovf_o;

  always #5 clk = ~clk;

  add_mop_acc #(.width(W), .depth(D), .speed(1), .cntw(CW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .in_mask_i(in_mask_i), .in_last_i(in_last_i),
    .abort_i(abort_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_sum_o(out_sum_o), .out_count_o(out_count_o), .out_ovf_o(out_ovf_o)
  );

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: exact job totals, result pending flag.
  longint m_sum = 0;
  longint m_cnt = 0;
  bit     m_hold = 1'b0;

  always @(posedge clk) begin
    if (rst_i) begin
      m_sum = 0; m_cnt = 0; m_hold = 1'b0;
    end else if (m_hold) begin
      if (out_ready_i) begin
        m_sum = 0; m_cnt = 0; m_hold = 1'b0;
      end
    end else if (abort_i) begin
      m_sum = 0; m_cnt = 0;
    end else if (in_valid_i) begin
      for (int k = 0; k < D; k++) begin
        if (in_mask_i[k]) begin
          m_sum += longint'(in_data_i[k*W +: W]);
          m_cnt += 1;
        end
      end
      if (in_last_i) m_hold = 1'b1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", longint'(in_ready_o), longint'(!m_hold && !abort_i));
      chk("out_valid", longint'(out_valid_o), longint'(m_hold));
      if (m_hold) begin
        chk("model_sum", longint'(out_sum_o), m_sum % (64'sd1 << W));
        chk("model_count", longint'(out_count_o), m_cnt % (64'sd1 << CW));
        chk("model_ovf", longint'(out_ovf_o),
            longint'((m_sum >= (64'sd1 << W)) || (m_cnt >= (64'sd1 << CW))));
      end
    end
  end

  int n_hs = 0;
  always @(posedge clk) begin
    if (!rst_i && out_valid_o && out_ready_i) n_hs++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input logic [D*W-1:0] d, input logic [D-1:0] m, input logic l);
    in_valid_i = 1'b1; in_data_i = d; in_mask_i = m; in_last_i = l;
    step();
    in_valid_i = 1'b0; in_data_i = '0; in_mask_i = '0; in_last_i = 1'b0;
  endtask

  task automatic finish_job();
    step();
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
  endtask

  task automatic lit(input string tag, input longint s, input longint c, input longint o);
    chk({tag, "_valid"}, longint'(out_valid_o), 1);
    chk({tag, "_sum"}, longint'(out_sum_o), s);
    chk({tag, "_count"}, longint'(out_count_o), c);
    chk({tag, "_ovf"}, longint'(out_ovf_o), o);
  endtask

  initial begin
    int jobs, cyc, beat_i, nbeats, hs_base;
    repeat (3) @(posedge clk);
    #2;
    rst_i = 1'b0;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_ready", longint'(in_ready_o), 1);
    chk("rst_valid", longint'(out_valid_o), 0);
    chk("rst_sum", longint'(out_sum_o), 0);
    chk("rst_count", longint'(out_count_o), 0);
    chk("rst_ovf", longint'(out_ovf_o), 0);
    step();

    // Single beat {1,2,3,4}
    beat(32'h04030201, 4'b1111, 1'b1);
    @(negedge clk);
    lit("t1", 10, 4, 0);
    chk("t1_ready", longint'(in_ready_o), 0);
    finish_job();
    @(negedge clk);
    chk("t1_released", longint'(out_valid_o), 0);
    step();

    // Three beats of 0xFF: carry loss
    beat(32'hFFFFFFFF, 4'b1111, 1'b0);
    beat(32'hFFFFFFFF, 4'b1111, 1'b0);
    beat(32'hFFFFFFFF, 4'b1111, 1'b1);
    @(negedge clk);
    lit("t2", 244, 12, 1);
    finish_job();

    // Partial mask then empty-mask last; result held while consumer stalls
    beat(32'h05050505, 4'b0101, 1'b0);
    beat(32'h00000000, 4'b0000, 1'b1);
    in_valid_i = 1'b1; in_data_i = 32'hFFFFFFFF; in_mask_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      lit("t3_hold", 10, 2, 0);
      chk("t3_ready", longint'(in_ready_o), 0);
      step();
    end
    in_valid_i = 1'b0; in_data_i = '0; in_mask_i = '0;
    finish_job();

    // Abort drops partial job
    beat(32'h01010101, 4'b1111, 1'b0);
    beat(32'h01010101, 4'b1111, 1'b0);
    abort_i = 1'b1; in_valid_i = 1'b1; in_data_i = 32'h01010101; in_mask_i = 4'b1111;
    @(negedge clk);
    chk("t4_abort_ready", longint'(in_ready_o), 0);
    step();
    abort_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; in_mask_i = '0;
    beat(32'h00000002, 4'b0001, 1'b1);
    @(negedge clk);
    lit("t4", 2, 1, 0);
    finish_job();

    // Reset while holding a result
    beat(32'h04030201, 4'b1111, 1'b1);
    @(negedge clk);
    lit("t5_pre", 10, 4, 0);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    @(negedge clk);
    chk("t5_valid", longint'(out_valid_o), 0);
    chk("t5_sum", longint'(out_sum_o), 0);
    chk("t5_count", longint'(out_count_o), 0);
    chk("t5_ready", longint'(in_ready_o), 1);
    step();

    // Count wrap: 64 beats x 4 lanes = 256 operands
    for (int i = 0; i < 64; i++) beat(32'h00000000, 4'b1111, (i == 63));
    @(negedge clk);
    lit("t6_wrap", 0, 0, 1);
    finish_job();

    // Random jobs
    hs_base = n_hs;
    jobs = 0; cyc = 0; beat_i = 0;
    nbeats = $urandom_range(1, 3);
    while (jobs < 1000 && cyc < 60000) begin
      in_valid_i  = ($urandom_range(0, 3) != 0);
      abort_i     = ($urandom_range(0, 39) == 0);
      in_data_i   = $urandom;
      in_mask_i   = 4'($urandom_range(0, 15));
      in_last_i   = (beat_i == nbeats - 1);
      out_ready_i = $urandom_range(0, 1) != 0;
      if (in_valid_i && !m_hold && !abort_i) begin
        if (in_last_i) begin
          jobs++;
          beat_i = 0;
          nbeats = $urandom_range(1, 3);
        end else begin
          beat_i++;
        end
      end
      step();
      cyc++;
    end
    in_valid_i = 1'b0; abort_i = 1'b0; in_last_i = 1'b0;
    in_data_i = '0; in_mask_i = '0; out_ready_i = 1'b1;
    repeat (3) step();
    chk("rand_jobs_done", longint'(jobs), 1000);
    chk("rand_results_delivered", longint'(n_hs - hs_base), longint'(jobs));
    out_ready_i = 1'b0;
    step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
